// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared instruction/data memory port (IFU = m0, LSU = m1).
// Optional build macro ARB_RR_EN selects round-robin arbitration; default is fixed priority to m1.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// ST_IDLE      | no transaction; winner of the requesters is accepted this cycle
// ST_REQ       | latched request presented on mem_req_*, waiting for mem_req_ready
// ST_WAIT_RESP | request issued, waiting for mem_resp_valid or the timeout
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_addr,
    input  logic        m0_wen,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    output logic        m0_resp_valid,
    output logic        m0_resp_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_addr,
    input  logic        m1_wen,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    output logic        m1_resp_valid,
    output logic        m1_resp_err,
    output logic [31:0] m1_rdata,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_wen,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_REQ       = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wmask_q, wmask_d;
    logic          wen_q, wen_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic any_req;
    logic grant_m1;
    logic accept;
    logic resp_fire;
    logic resp_err;
    logic resp_vld;

`ifdef ARB_RR_EN
    logic last_owner_q, last_owner_d;

    // On a tie the master that was not granted last wins; reset value 1 favours m0 first.
    always_comb begin
        any_req = m0_req_valid | m1_req_valid;
        if (m0_req_valid && m1_req_valid) begin
            grant_m1 = ~last_owner_q;
        end else begin
            grant_m1 = m1_req_valid;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (accept) begin
            last_owner_d = grant_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    always_comb begin
        any_req  = m0_req_valid | m1_req_valid;
        grant_m1 = m1_req_valid;
    end
`endif

    // Timeout is a down-counter loaded on entry to ST_WAIT_RESP; terminal count 0 is the error cycle.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        wen_d     = wen_q;
        tmr_d     = tmr_q;
        accept    = 1'b0;
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                    owner_d = grant_m1;
                    addr_d  = grant_m1 ? m1_addr  : m0_addr;
                    wdata_d = grant_m1 ? m1_wdata : m0_wdata;
                    wmask_d = grant_m1 ? m1_wmask : m0_wmask;
                    wen_d   = grant_m1 ? m1_wen   : m0_wen;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT_RESP;
                    tmr_d   = TMR_LOAD;
                end
            end
            ST_WAIT_RESP: begin
                if (mem_resp_valid) begin
                    resp_fire = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tmr_q == '0) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            wen_q   <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wen_q   <= wen_d;
            tmr_q   <= tmr_d;
        end
    end

    // Handshakes are masked while rst is high: anything accepted or answered then would be lost.
    always_comb begin
        m0_req_ready  = accept & ~grant_m1 & ~rst;
        m1_req_ready  = accept &  grant_m1 & ~rst;
        resp_vld      = resp_fire & ~rst;

        m0_resp_valid = resp_vld & ~owner_q;
        m1_resp_valid = resp_vld &  owner_q;
        m0_resp_err   = m0_resp_valid & resp_err;
        m1_resp_err   = m1_resp_valid & resp_err;
        m0_rdata      = (m0_resp_valid && !resp_err) ? mem_rdata : '0;
        m1_rdata      = (m1_resp_valid && !resp_err) ? mem_rdata : '0;

        mem_req_valid = (state_q == ST_REQ);
        mem_addr      = addr_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
        mem_wen       = wen_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction table driven through the arbiter with a
// response scoreboard, plus a hand-written mid-transaction reset sequence.
module tb_mem_arbiter;

    localparam int TO = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        wen;
    } req_t;

    typedef struct {
        bit          m0_v;
        bit          m1_v;
        req_t        r0;
        req_t        r1;
        int          rdy_dly;
        int          rsp_dly;
        bit          stray;
        logic [31:0] rdata;
        bit          own_fix;
        bit          own_rr;
    } vec_t;

    typedef struct {
        bit          owner;
        bit          err;
        logic [31:0] rdata;
        int          k;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid, m0_resp_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wmask;
    logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    vec_t tbl[10];

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_resp_valid(m0_resp_valid), .m0_resp_err(m0_resp_err), .m0_rdata(m0_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_resp_valid(m1_resp_valid), .m1_resp_err(m1_resp_err), .m1_rdata(m1_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_wen(mem_wen),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk1({tag, "_m0_rdy"}, m0_req_ready, 1'b0);
        chk1({tag, "_m1_rdy"}, m1_req_ready, 1'b0);
        chk1({tag, "_m0_rv"}, m0_resp_valid, 1'b0);
        chk1({tag, "_m1_rv"}, m1_resp_valid, 1'b0);
        chk1({tag, "_m0_err"}, m0_resp_err, 1'b0);
        chk1({tag, "_m1_err"}, m1_resp_err, 1'b0);
        chk32({tag, "_m0_rdata"}, m0_rdata, 32'h0);
        chk32({tag, "_m1_rdata"}, m1_rdata, 32'h0);
        chk1({tag, "_mem_v"}, mem_req_valid, 1'b0);
        chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk32({tag, "_mem_wmask"}, {28'h0, mem_wmask}, 32'h0);
        chk1({tag, "_mem_wen"}, mem_wen, 1'b0);
    endtask

    function automatic req_t mkr(input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] m, input logic w);
        req_t r;
        r.addr  = a;
        r.wdata = d;
        r.wmask = m;
        r.wen   = w;
        return r;
    endfunction

    function automatic vec_t mkv(input bit m0v, input bit m1v, input req_t r0, input req_t r1,
                                 input int rdy, input int rsp, input bit stray,
                                 input logic [31:0] rd, input bit ofix, input bit orr);
        vec_t v;
        v.m0_v = m0v; v.m1_v = m1v; v.r0 = r0; v.r1 = r1;
        v.rdy_dly = rdy; v.rsp_dly = rsp; v.stray = stray; v.rdata = rd;
        v.own_fix = ofix; v.own_rr = orr;
        return v;
    endfunction

    // Entered just after a rising edge; returns just after the rising edge that ends the response cycle.
    task automatic run_vec(input vec_t v, input int idx);
        bit   own;
        bit   got;
        req_t w;
        exp_t e;
        exp_t x;
`ifdef ARB_RR_EN
        own = v.own_rr;
`else
        own = v.own_fix;
`endif
        w = own ? v.r1 : v.r0;
        m0_req_valid = v.m0_v; m0_addr = v.r0.addr; m0_wdata = v.r0.wdata;
        m0_wmask = v.r0.wmask; m0_wen = v.r0.wen;
        m1_req_valid = v.m1_v; m1_addr = v.r1.addr; m1_wdata = v.r1.wdata;
        m1_wmask = v.r1.wmask; m1_wen = v.r1.wen;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        chk1($sformatf("v%0d_acc_m0_rdy", idx), m0_req_ready, !own);
        chk1($sformatf("v%0d_acc_m1_rdy", idx), m1_req_ready, own);
        chk1($sformatf("v%0d_acc_mem_v", idx), mem_req_valid, 1'b0);
        e.owner = own;
        e.err   = (v.rsp_dly > TO);
        e.rdata = e.err ? 32'h0 : v.rdata;
        e.k     = e.err ? TO : v.rsp_dly;
        sb.push_back(e);
        @(posedge clk); #1;

        for (int c = 0; c <= v.rdy_dly; c++) begin
            mem_req_ready  = (c == v.rdy_dly);
            mem_resp_valid = v.stray;
            mem_rdata      = 32'hBAD0_0000 | 32'(c);
            @(negedge clk);
            chk1($sformatf("v%0d_req_mem_v", idx), mem_req_valid, 1'b1);
            chk32($sformatf("v%0d_req_addr", idx), mem_addr, w.addr);
            chk32($sformatf("v%0d_req_wdata", idx), mem_wdata, w.wdata);
            chk32($sformatf("v%0d_req_wmask", idx), {28'h0, mem_wmask}, {28'h0, w.wmask});
            chk1($sformatf("v%0d_req_wen", idx), mem_wen, w.wen);
            chk1($sformatf("v%0d_req_m0_rdy", idx), m0_req_ready, 1'b0);
            chk1($sformatf("v%0d_req_m1_rdy", idx), m1_req_ready, 1'b0);
            chk1($sformatf("v%0d_req_m0_rv", idx), m0_resp_valid, 1'b0);
            chk1($sformatf("v%0d_req_m1_rv", idx), m1_resp_valid, 1'b0);
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;

        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            mem_resp_valid = (k == v.rsp_dly);
            mem_rdata      = v.rdata;
            @(negedge clk);
            chk1($sformatf("v%0d_wait_m0_rdy", idx), m0_req_ready, 1'b0);
            chk1($sformatf("v%0d_wait_m1_rdy", idx), m1_req_ready, 1'b0);
            chk1($sformatf("v%0d_wait_mem_v", idx), mem_req_valid, 1'b0);
            if (m0_resp_valid || m1_resp_valid) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL v%0d_sb_empty: response with no expectation queued", idx);
                end else begin
                    x = sb.pop_front();
                    chk1($sformatf("v%0d_rsp_m0_rv", idx), m0_resp_valid, !x.owner);
                    chk1($sformatf("v%0d_rsp_m1_rv", idx), m1_resp_valid, x.owner);
                    chk1($sformatf("v%0d_rsp_err", idx), x.owner ? m1_resp_err : m0_resp_err, x.err);
                    chk1($sformatf("v%0d_rsp_other_err", idx), x.owner ? m0_resp_err : m1_resp_err, 1'b0);
                    chk32($sformatf("v%0d_rsp_rdata", idx), x.owner ? m1_rdata : m0_rdata, x.rdata);
                    chk32($sformatf("v%0d_rsp_other_rdata", idx), x.owner ? m0_rdata : m1_rdata, 32'h0);
                    chk32($sformatf("v%0d_rsp_cycle", idx), 32'(k), 32'(x.k));
                end
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL v%0d_no_resp: got none expected a response within 40 cycles", idx);
        end
        mem_resp_valid = 1'b0;
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mkv(1, 1, mkr(32'h0000_0100, 32'h0, 4'h0, 0), mkr(32'h0000_0200, 32'h0, 4'h0, 0),
                     0, 0, 0, 32'h1111_0000, 1, 0);
        tbl[1] = mkv(1, 1, mkr(32'h0000_0104, 32'h0, 4'h0, 0), mkr(32'h0000_0204, 32'h0, 4'h0, 0),
                     0, 1, 0, 32'h2222_0000, 1, 1);
        tbl[2] = mkv(1, 1, mkr(32'h0000_0108, 32'h0, 4'h0, 0), mkr(32'h0000_0208, 32'h0, 4'h0, 0),
                     1, 0, 0, 32'h3333_0000, 1, 0);
        tbl[3] = mkv(1, 1, mkr(32'h0000_010C, 32'h0, 4'h0, 0), mkr(32'h0000_020C, 32'h0, 4'h0, 0),
                     0, 2, 0, 32'h4444_0000, 1, 1);
        tbl[4] = mkv(1, 0, mkr(32'h8000_0000, 32'h0, 4'h0, 0), mkr(32'h0, 32'h0, 4'h0, 0),
                     0, 0, 0, 32'h0000_0413, 0, 0);
        tbl[5] = mkv(0, 1, mkr(32'h0, 32'h0, 4'h0, 0), mkr(32'h0000_3000, 32'hDEAD_BEEF, 4'hF, 1),
                     2, 1, 1, 32'h0000_1234, 1, 1);
        tbl[6] = mkv(1, 1, mkr(32'h0000_0500, 32'hA5A5_0001, 4'h3, 1), mkr(32'h0000_0600, 32'h5A5A_0002, 4'hC, 1),
                     5, 0, 0, 32'h0000_0006, 1, 0);
        tbl[7] = mkv(0, 1, mkr(32'h0, 32'h0, 4'h0, 0), mkr(32'h0000_0700, 32'h0, 4'h0, 0),
                     0, 99, 0, 32'hFFFF_FFFF, 1, 1);
        tbl[8] = mkv(1, 0, mkr(32'h0000_0800, 32'h0, 4'h0, 0), mkr(32'h0, 32'h0, 4'h0, 0),
                     0, 3, 0, 32'h0808_0808, 0, 0);
        tbl[9] = mkv(0, 1, mkr(32'h0, 32'h0, 4'h0, 0), mkr(32'h0000_0900, 32'h0, 4'h0, 0),
                     0, TO, 0, 32'h0909_0909, 1, 1);

        rst = 1'b1;
        m0_req_valid = 1'b1; m0_addr = 32'h1234_5678; m0_wen = 1'b1; m0_wdata = 32'hFFFF_FFFF; m0_wmask = 4'hF;
        m1_req_valid = 1'b0; m1_addr = 32'h0; m1_wen = 1'b0; m1_wdata = 32'h0; m1_wmask = 4'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_idle_outputs("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        m0_req_valid = 1'b0;
        mem_resp_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i], i);
        end

        // Reset while waiting for the memory response drops the transaction silently.
        m0_req_valid = 1'b1; m0_addr = 32'h0000_0040; m0_wen = 1'b0; m0_wdata = 32'h0; m0_wmask = 4'h0;
        @(negedge clk);
        chk1("rs_acc_m0_rdy", m0_req_ready, 1'b1);
        @(posedge clk); #1;
        m0_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk1("rs_req_mem_v", mem_req_valid, 1'b1);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk1("rs_rst_m0_rv", m0_resp_valid, 1'b0);
        chk1("rs_rst_m1_rv", m1_resp_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("rs_after");
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;

        run_vec(mkv(1, 0, mkr(32'h0000_0044, 32'h0, 4'h0, 0), mkr(32'h0, 32'h0, 4'h0, 0),
                    0, 0, 0, 32'h0000_0044, 0, 0), 10);

        chk32("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single instruction/data memory port between the fetch unit (master 0) and the load/store unit (master 1). It accepts one request at a time over valid/ready handshakes, forwards it to the memory port and routes the response back to the owning master. A response timeout converts a hung memory access into an error response. It sits between IFU/LSU and the memory interface.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT_RESP before an error response; width of the timeout counter is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous, active-high reset
- m0_req_valid / m1_req_valid  input  1  master request valid
- m0_req_ready / m1_req_ready  output  1  request accepted this cycle
- m0_addr / m1_addr  input  32  byte address
- m0_wen / m1_wen  input  1  1 = write, 0 = read
- m0_wdata / m1_wdata  input  32  write data
- m0_wmask / m1_wmask  input  4  byte write mask
- m0_resp_valid / m1_resp_valid  output  1  one-cycle response pulse
- m0_resp_err / m1_resp_err  output  1  response is a timeout error (qualified by resp_valid)
- m0_rdata / m1_rdata  output  32  read data (qualified by resp_valid)
- mem_req_valid  output  1  request to memory
- mem_req_ready  input  1  memory accepts request
- mem_addr / mem_wdata / mem_wmask / mem_wen  output  32/32/4/1  latched request fields
- mem_resp_valid  input  1  memory response
- mem_rdata  input  32  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT_RESP. Reset: IDLE.
- IDLE: if any mX_req_valid, select winner (see Configuration), assert winner's mX_req_ready combinationally this cycle, latch addr/wen/wdata/wmask and owner, go REQ. Loser's req_ready = 0. No valid -> stay.
- REQ: mem_req_valid = 1 with latched fields; on mem_req_ready go WAIT_RESP, clear timeout counter.
- WAIT_RESP: on mem_resp_valid, owner's resp_valid = 1, resp_err = 0, rdata = mem_rdata (combinational pass-through); go IDLE. Else counter increments; when counter == TIMEOUT_CYCLES and no mem_resp_valid, owner's resp_valid = 1, resp_err = 1, rdata = 0; go IDLE.
- Writes also complete by mem_resp_valid; rdata undefined-but-passed.
- mem_resp_valid in IDLE or REQ is ignored. Non-owner resp_valid always 0.
- Only one outstanding transaction; req_ready is 0 in REQ and WAIT_RESP.
- Reset mid-operation: return to IDLE, drop transaction, no response issued, mem_req_valid deasserts next cycle.

## Timing
- Reset values: all req_ready, resp_valid, resp_err, mem_req_valid = 0; mem_addr/wdata/wmask/wen = 0; rdata = 0 when not valid.
- Accept in cycle N -> mem_req_valid from N+1. mem_req_ready in N+1 -> earliest resp in N+2 (same cycle as mem_resp_valid). Minimum round trip: 2 cycles after acceptance.
- Next acceptance possible in the cycle after resp (IDLE re-entered).
- Timeout: error response exactly TIMEOUT_CYCLES+1 cycles after entering WAIT_RESP if no response; mem_resp_valid in that same cycle wins (normal response).
- mem_* request outputs held stable while mem_req_valid && !mem_req_ready.

## Configuration
- ARB_RR_EN defined: round-robin; a 1-bit last_owner register (reset 1, so master 0 wins the first tie) updates on each grant; on simultaneous requests the master not granted last wins.
- ARB_RR_EN undefined: fixed priority, master 1 (LSU) always wins simultaneous requests; last_owner not implemented.
- Single requester is granted immediately in both modes.

## Test plan
- Single m0 read addr 0x80000000, mem ready immediately, mem_resp rdata 0x00000413 two cycles later -> m0_req_ready at N, mem_req_valid N+1, m0_resp_valid with rdata 0x00000413, m1 silent.
- Both masters request every cycle, 4 transactions -> with ARB_RR_EN grants m0,m1,m0,m1; without, m1,m1,m1,m1 and m0_req_ready never high.
- mem_req_ready held low 5 cycles -> mem_addr/wdata/wmask stable, no req_ready to either master until completion.
- TIMEOUT_CYCLES=8, no mem_resp_valid -> owner resp_valid=1, resp_err=1, rdata=0 exactly 9 cycles after entering WAIT_RESP; arbiter accepts next request the following cycle.
- m1 write 0xDEADBEEF mask 0xF, stray mem_resp_valid during REQ -> ignored; only response in WAIT_RESP delivered to m1.
- Assert rst during WAIT_RESP -> next cycle IDLE, all outputs at reset values, no resp_valid; subsequent m0 request completes normally.
